// File: rtl/midi_event_tx.sv
// rtl/midi_event_tx.sv - MIDI event framer and 31250-baud 8N1 serialiser
// Optional running-status compression: define MIDI_TX_RUNNING_STATUS_EN.
module midi_event_tx #(
    parameter int CLK_DIV = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       midi_event_valid,
    input  logic [7:0] midi_command,
    input  logic [6:0] midi_parameter_1,
    input  logic [6:0] midi_parameter_2,
    output logic       midi_event_ack,
    output logic       serial_tx,
    output logic       busy
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t       state, state_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]   bit_idx;
    logic [1:0]   byte_idx, last_q, last_idx, first_idx;
    logic [7:0]   cmd_q, cur_byte;
    logic [6:0]   p1_q, p2_q;
    logic         accept, bit_done;

    assign accept   = midi_event_valid && (state == IDLE) && !midi_event_ack;
    assign bit_done = (baud_cnt == CNT_MAX);

    // Byte positions: 0 = status, 1 = first data byte, 2 = second data byte.
    always_comb begin
        last_idx = 2'd2;
        case (midi_command[7:4])
            4'hC, 4'hD: last_idx = 2'd1;
            4'hF:       last_idx = 2'd0;
            default:    last_idx = 2'd2;
        endcase
    end

`ifdef MIDI_TX_RUNNING_STATUS_EN
    logic [7:0] rs_q;
    logic       channel_voice;

    assign channel_voice = (midi_command[7:4] != 4'hF);
    assign first_idx     = (channel_voice && midi_command == rs_q) ? 2'd1 : 2'd0;

    // Real-time bytes (0xF8-0xFF) must not disturb an ongoing running status.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q <= 8'h00;
        end else if (accept && midi_command[7]) begin
            if (channel_voice)
                rs_q <= midi_command;
            else if (!midi_command[3])
                rs_q <= 8'h00;
        end
    end
`else
    assign first_idx = 2'd0;
`endif

    always_comb begin
        case (byte_idx)
            2'd0:    cur_byte = cmd_q;
            2'd1:    cur_byte = {1'b0, p1_q};
            default: cur_byte = {1'b0, p2_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            baud_cnt       <= '0;
            bit_idx        <= 3'd0;
            byte_idx       <= 2'd0;
            last_q         <= 2'd0;
            cmd_q          <= 8'h00;
            p1_q           <= 7'h00;
            p2_q           <= 7'h00;
            midi_event_ack <= 1'b0;
        end else begin
            state          <= state_next;
            midi_event_ack <= accept;
            if (state == IDLE || state_next != state || bit_done)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;
            if (accept) begin
                cmd_q    <= midi_command;
                p1_q     <= midi_parameter_1;
                p2_q     <= midi_parameter_2;
                last_q   <= last_idx;
                byte_idx <= first_idx;
                bit_idx  <= 3'd0;
            end
            if (state == DATA && bit_done)
                bit_idx <= bit_idx + 3'd1;
            if (state == STOP && bit_done)
                byte_idx <= byte_idx + 2'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept && midi_command[7]) state_next = START;
            START: if (bit_done) state_next = DATA;
            DATA:  if (bit_done && bit_idx == 3'd7) state_next = STOP;
            STOP:  if (bit_done) state_next = (byte_idx == last_q) ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        serial_tx = 1'b1;
        case (state)
            START:   serial_tx = 1'b0;
            DATA:    serial_tx = cur_byte[bit_idx];
            default: serial_tx = 1'b1;
        endcase
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_midi_event_tx.sv
// tb/tb_midi_event_tx.sv - scoreboard bench for midi_event_tx with line decoder
module tb_midi_event_tx;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic [6:0] p1 = 7'h00, p2 = 7'h00;
    logic       ack, tx, busy;

    always #5 clk = ~clk;

    midi_event_tx #(.CLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .midi_event_valid(valid), .midi_command(cmd),
        .midi_parameter_1(p1), .midi_parameter_2(p2),
        .midi_event_ack(ack), .serial_tx(tx), .busy(busy)
    );

    int checks = 0, errors = 0;
    logic [7:0] exp_bytes[$];
    int exp_len[$];
    int ack_count = 0, issued = 0;
    int last_gap = 1000;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    logic [7:0] model_rs = 8'h00;
`endif

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Reference: which bytes a MIDI event puts on the wire, by message type.
    task automatic push_expected(input logic [7:0] c, input logic [6:0] a, input logic [6:0] b);
        logic [7:0] msg[3];
        int n, first;
        if (!c[7]) return;
        if (c >= 8'hF0) n = 1;
        else if (c >= 8'hC0 && c < 8'hE0) n = 2;
        else n = 3;
        msg[0] = c; msg[1] = {1'b0, a}; msg[2] = {1'b0, b};
        first = 0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
        if (c < 8'hF0) begin
            if (c == model_rs) first = 1;
            else model_rs = c;
        end else if (c < 8'hF8) begin
            model_rs = 8'h00;
        end
`endif
        for (int i = first; i < n; i++) exp_bytes.push_back(msg[i]);
        exp_len.push_back((n - first) * 10 * D);
    endtask

    always @(negedge clk) if (ack) ack_count++;

    int  dt = 0;
    bit  dact = 1'b0;
    logic [7:0] sh = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            dact = 1'b0;
        end else begin
            if (!dact && tx == 1'b0) begin
                dact = 1'b1;
                dt = 0;
            end else if (dact) begin
                dt++;
            end
            if (dact) begin
                if (dt == D / 2) check("start_bit", tx, 0);
                for (int k = 1; k <= 8; k++)
                    if (dt == k * D + D / 2) sh[k-1] = tx;
                if (dt == 9 * D + D / 2) begin
                    check("stop_bit", tx, 1);
                    if (exp_bytes.size() == 0) fail_now("unexpected_byte");
                    else check("byte", sh, exp_bytes.pop_front());
                    dact = 1'b0;
                end
            end
        end
    end

    int  blen = 0, gap = 1000;
    bit  bact = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            bact = 1'b0;
            gap = 1000;
        end else if (busy) begin
            if (!bact) begin
                bact = 1'b1;
                last_gap = gap;
                blen = 1;
            end else begin
                blen++;
            end
        end else begin
            if (bact) begin
                bact = 1'b0;
                gap = 1;
                if (exp_len.size() == 0) fail_now("unexpected_busy");
                else check("busy_len", blen, exp_len.pop_front());
            end else if (gap < 1000) begin
                gap++;
            end
        end
    end

    task automatic send(input logic [7:0] c, input logic [6:0] a, input logic [6:0] b, input bit hold);
        int n;
        @(posedge clk); #1;
        cmd = c; p1 = a; p2 = b; valid = 1'b1;
        push_expected(c, a, b);
        issued++;
        n = 0;
        @(negedge clk);
        while (!ack && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!ack) fail_now("ack_timeout");
        @(posedge clk); #1;
        if (!hold) valid = 1'b0;
        @(negedge clk);
        check("ack_pulse", ack, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || dact) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (busy || dact) fail_now("idle_timeout");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bit bad;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);

        send(8'h90, 7'h3C, 7'h64, 1'b0);
        wait_idle();
        send(8'hC5, 7'h07, 7'h7F, 1'b0);
        wait_idle();

        send(8'h3C, 7'h00, 7'h00, 1'b0);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        check("drop_quiet", bad, 0);

        send(8'h80, 7'h01, 7'h02, 1'b1);
        send(8'hE3, 7'h7F, 7'h00, 1'b0);
        check("b2b_gap", last_gap, 1);
        wait_idle();

        send(8'h91, 7'h40, 7'h50, 1'b0);
        send(8'hF8, 7'h00, 7'h00, 1'b0);
        send(8'h91, 7'h41, 7'h00, 1'b0);
        wait_idle();

        repeat (20) send(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)),
                         7'($urandom_range(0, 127)), 1'b0);
        wait_idle();

        send(8'h93, 7'h11, 7'h22, 1'b0);
        repeat (4 * D) @(negedge clk);
        check("pre_rst_bit3", tx, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_bytes.delete();
        exp_len.delete();
`ifdef MIDI_TX_RUNNING_STATUS_EN
        model_rs = 8'h00;
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        send(8'h91, 7'h41, 7'h00, 1'b0);
        wait_idle();

        check("bytes_left", exp_bytes.size(), 0);
        check("lens_left", exp_len.size(), 0);
        check("ack_count", ack_count, issued);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
